// File: rtl/jzjcoref_pkg.sv
// Shared types and constants for the integer register file.
//   regAddr_t      : 5-bit register index
//   word_t         : 32-bit register data
//   regFileState_t : clear sequencer state (CLEARING, READY)
//   REG_ZERO       : index of the hardwired-zero register
//   REG_LAST       : highest register index, last entry cleared
package jzjcoref_pkg;

  typedef logic [4:0]  regAddr_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } regFileState_t;

  localparam regAddr_t REG_ZERO = 5'd0;
  localparam regAddr_t REG_LAST = 5'd31;

endpackage

// File: rtl/rd_register_file_clear_fsm.sv
// Post-reset clear sequencer for the register file array.
// Walks every entry once after reset so the array itself never needs a reset.
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   ready      out  high once every entry has been cleared
//   clear_we   out  clear-write strobe for the current edge
//   clear_addr out  entry being cleared at the current edge
//
// state    | meaning
// ---------+-----------------------------------------------------
// CLEARING | writing 0 to entry[count_q] at each edge, ready low
// READY    | array fully cleared, normal reads/writes allowed
module rd_register_file_clear_fsm
  import jzjcoref_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  output logic     ready,
  output logic     clear_we,
  output regAddr_t clear_addr
);

  regFileState_t state_q, state_d;
  regAddr_t      count_q, count_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= CLEARING;
      count_q <= REG_ZERO;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    clear_we   = 1'b0;
    clear_addr = count_q;
    case (state_q)
      CLEARING: begin
        // Gated by reset so the reset edge itself never touches the array.
        clear_we = reset;
        if (count_q == REG_LAST) begin
          state_d = READY;
        end else begin
          count_d = count_q + 5'd1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEARING;
      end
    endcase
    // ready is registered alongside the state so the output is a plain flop.
    ready_d = (state_d == READY);
  end

  assign ready = ready_q;

endmodule

// File: rtl/rd_register_file.sv
// RV32I integer register file: 32 x 32-bit, x0 reads as zero, registered
// reads with write-to-read bypass, cleared by a sequencer after reset.
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-low reset
//   rdWriteEnable in   write rd into rdAddress at this edge
//   rdAddress     in   destination register index
//   rd            in   write-back data
//   rs1Address    in   source register 1 index
//   rs2Address    in   source register 2 index
//   rs1           out  registered read data for rs1Address
//   rs2           out  registered read data for rs2Address
//   ready         out  high once the clear sequence has finished
module rd_register_file
  import jzjcoref_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        rdWriteEnable,
  input  logic [4:0]  rdAddress,
  input  logic [31:0] rd,
  input  logic [4:0]  rs1Address,
  input  logic [4:0]  rs2Address,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic        ready
);

  logic     clear_we;
  regAddr_t clear_addr;

  rd_register_file_clear_fsm u_clear_fsm (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  word_t    mem [32];
  logic     user_we;
  logic     mem_we;
  regAddr_t mem_waddr;
  word_t    mem_wdata;
  word_t    rs1_q, rs1_d;
  word_t    rs2_q, rs2_d;

  // Writes to x0 are dropped here so the bypass never forwards them either.
  assign user_we   = reset && ready && rdWriteEnable && (rdAddress != REG_ZERO);
  assign mem_we    = clear_we || user_we;
  assign mem_waddr = clear_we ? clear_addr : rdAddress;
  assign mem_wdata = clear_we ? '0 : rd;

  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  function automatic word_t read_port(input regAddr_t addr, input logic rdy,
                                      input logic wr_hit, input word_t wr_data,
                                      input word_t arr_data);
    word_t r;
    r = '0;
    if (rdy && addr != REG_ZERO) begin
      r = wr_hit ? wr_data : arr_data;
    end
    return r;
  endfunction

  always_comb begin
    rs1_d = read_port(rs1Address, ready, user_we && (rdAddress == rs1Address),
                      rd, mem[rs1Address]);
    rs2_d = read_port(rs2Address, ready, user_we && (rdAddress == rs2Address),
                      rd, mem[rs2Address]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign rs1 = rs1_q;
  assign rs2 = rs2_q;

endmodule

// File: tb/tb_rd_register_file.sv
module tb_rd_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rdWriteEnable = 1'b0;
  logic [4:0]  rdAddress = '0;
  logic [31:0] rd = '0;
  logic [4:0]  rs1Address = '0;
  logic [4:0]  rs2Address = '0;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;

  rd_register_file dut (
    .clock         (clock),
    .reset         (reset),
    .rdWriteEnable (rdWriteEnable),
    .rdAddress     (rdAddress),
    .rd            (rd),
    .rs1Address    (rs1Address),
    .rs2Address    (rs2Address),
    .rs1           (rs1),
    .rs2           (rs2),
    .ready         (ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  bit          tb_ready = 1'b0;
  int          edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  // Monitor: every read result due at this edge is compared once it settles.
  always @(posedge clock) begin
    exp_t cur;
    edge_cnt++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc != edge_cnt || rs1 !== cur.e1 || rs2 !== cur.e2) begin
        errors++;
        $display("FAIL %s: rs1=%h rs2=%h expected rs1=%h rs2=%h (edge %0d due %0d)",
                 cur.name, rs1, rs2, cur.e1, cur.e2, edge_cnt, cur.cyc);
      end
    end
  end

  function automatic logic [31:0] exp_rs(input logic [4:0] a, input bit we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (!tb_ready || a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // One cycle of stimulus: inputs driven at the negedge, expectation queued
  // for the following rising edge.
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2, input string nm);
    exp_t e;
    @(negedge clock);
    rdWriteEnable = we;
    rdAddress     = wa;
    rd            = wd;
    rs1Address    = a1;
    rs2Address    = a2;
    e.cyc  = edge_cnt + 1;
    e.e1   = exp_rs(a1, we, wa, wd);
    e.e2   = exp_rs(a2, we, wa, wd);
    e.name = nm;
    sb.push_back(e);
    if (tb_ready && we && wa != 5'd0) model[wa] = wd;
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b0;
      rdWriteEnable = 1'b0;
    end
    tb_ready = 1'b0;
  endtask

  // Release reset and walk the 32 clear edges, trying to write x5 throughout.
  task automatic clear_seq();
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check_val("rs1_after_reset", rs1, 32'h0);
        check_val("rs2_after_reset", rs2, 32'h0);
      end
      check_val($sformatf("ready_low_%0d", i), {31'h0, ready}, 32'h0);
      reset         = 1'b1;
      rdWriteEnable = 1'b1;
      rdAddress     = 5'd5;
      rd            = 32'hDEADBEEF;
      rs1Address    = 5'd5;
      rs2Address    = 5'd5;
    end
    @(negedge clock);
    check_val("ready_high", {31'h0, ready}, 32'h1);
    check_val("rs1_clearing_zero", rs1, 32'h0);
    rdWriteEnable = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    tb_ready = 1'b1;
  endtask

  initial begin
    logic [4:0]  wa, a1, a2;
    logic [31:0] wd;
    bit          we;

    apply_reset(3);
    clear_seq();

    cyc(0, 5'd0, 32'h0, 5'd5, 5'd0, "x5_cleared");
    cyc(1, 5'd10, 32'h12345678, 5'd0, 5'd0, "write_x10");
    cyc(0, 5'd0, 32'h0, 5'd10, 5'd0, "read_x10");
    cyc(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "write_x0");
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, "read_x0");
    cyc(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "x0_bypass");
    cyc(1, 5'd7, 32'h11111111, 5'd0, 5'd0, "write_x7_old");
    cyc(1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, "bypass_x7");
    cyc(0, 5'd0, 32'h0, 5'd7, 5'd7, "read_x7");
    cyc(1, 5'd3, 32'h1, 5'd0, 5'd0, "write_x3");
    cyc(1, 5'd4, 32'h2, 5'd3, 5'd0, "write_x4");
    cyc(0, 5'd0, 32'h0, 5'd3, 5'd4, "dual_read");
    cyc(0, 5'd0, 32'h0, 5'd4, 5'd3, "dual_read_swap");
    cyc(1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd10, "bypass_rs1_only");

    // Reset after 10 clearing edges must restart the full 32-edge clear.
    apply_reset(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      reset = 1'b1;
    end
    apply_reset(1);
    clear_seq();

    for (int i = 1; i < 32; i++) cyc(1, 5'(i), 32'(i), 5'(i - 1), 5'(i), "fill");
    cyc(0, 5'd0, 32'h0, 5'd31, 5'd17, "fill_readback");
    apply_reset(2);
    clear_seq();
    for (int i = 0; i < 32; i++) cyc(0, 5'd0, 32'h0, 5'(i), 5'((i + 16) % 32), "after_reset_zero");

    for (int n = 0; n < 10000; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(we, wa, wd, a1, a2, "random");
    end

    @(negedge clock);
    rdWriteEnable = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_register_file.md
# rd_register_file

Integer register file that consumes the write-back value `rd` produced by the write-back source selector and supplies `rs1`/`rs2` operands to the ALU, branch ALU and memory address logic. It has 32 × 32-bit entries, x0 hardwired to zero, registered (1-cycle) reads with write-to-read bypass, and a post-reset clear sequencer so the array can map onto FPGA block RAM that cannot be reset in one cycle.

## Interface
Parameters:
- none; widths are fixed by RV32I (32 entries, 32-bit data, 5-bit addresses)

Ports:
- `clock`  in  1  the single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `rdWriteEnable`  in  1  write `rd` into `rdAddress` at this edge
- `rdAddress`  in  5  destination register index
- `rd`  in  32  write-back data from the write-back source selector
- `rs1Address`  in  5  source register 1 index, sampled at the edge
- `rs2Address`  in  5  source register 2 index, sampled at the edge
- `rs1`  out  32  registered read data for `rs1Address` sampled at the previous edge
- `rs2`  out  32  registered read data for `rs2Address` sampled at the previous edge
- `ready`  out  1  high once the clear sequence has finished; writes and reads are valid only while high

## Operation
- Sequencer states: CLEARING, READY.
- Reset (`reset` low at an edge): state ← CLEARING, clear counter ← 0, `rs1` = `rs2` = 0, `ready` = 0. Array contents are not touched during reset itself.
- CLEARING: each edge with `reset` high writes 0 to entry[counter] and increments the 5-bit counter. An edge with counter = 31 writes entry 31 and moves to READY. The counter does not wrap in use.
- While CLEARING: `rdWriteEnable` is ignored, `rs1`/`rs2` register 0, and `ready` = 0.
- READY: on each edge with `rdWriteEnable` = 1 and `rdAddress` ≠ 0, entry[`rdAddress`] ← `rd`. Writes to x0 are dropped.
- Reads in READY: `rsN` ← 0 if `rsNAddress` = 0. Otherwise `rsN` ← `rd` if a write to the same address is committed at this edge (bypass). Otherwise `rsN` ← entry[`rsNAddress`].
- `rs1` and `rs2` resolve independently. Both may hit the same address or the bypass in the same cycle.
- Reset asserted mid-clear or mid-operation restarts the sequence from counter 0. Any write presented at that edge is discarded.

## Timing
- Clear latency: `ready` rises after the 32nd rising edge with `reset` high, following the reset edge. It stays high until the next reset.
- Read latency: 1 cycle. An address presented before edge N gives data on `rsN` after edge N, held until edge N+1.
- Write latency: 1 cycle. Data written at edge N is visible through the array to an address sampled at edge N+1 or later. The bypass covers reads sampled at edge N itself.
- No combinational path from any input to any output; all outputs are flops.

## Structure
- Shared package `jzjcoref_pkg`:
  - `regAddr_t` (logic [4:0])
  - `word_t` (logic [31:0])
  - sequencer state enum `regFileState_t` {CLEARING, READY}
  - constant `REG_ZERO` = 5'd0
- One sub-module `rd_register_file_clear_fsm` owns the state, the counter and `ready`. It outputs the clear-write address and a clear-write strobe.
- The top level owns the array, the write mux (clear vs. `rd`) and the two bypassing read ports. The array is written as inferable RAM with no reset.

## Test plan
- Reset low 3 cycles, then high: `ready` = 0 for exactly 32 edges and 1 after. During clearing, write 0xDEADBEEF to x5: after `ready`, reading x5 → 0x00000000.
- After `ready`, write 0x12345678 to x10, then next cycle read `rs1Address` = 10 → `rs1` = 0x12345678 one edge later. Write 0xFFFFFFFF to x0, then read x0 → 0.
- Bypass: in one cycle write 0xCAFEF00D to x7 with `rs1Address` = `rs2Address` = 7 → both outputs = 0xCAFEF00D after that edge. The old value of x7 must never appear.
- Dual read: x3 = 0x1, x4 = 0x2; `rs1Address` = 3, `rs2Address` = 4 → `rs1` = 0x1, `rs2` = 0x2 in the same cycle.
- Reset mid-clear after 10 edges: `ready` needs a full 32 edges after release. Fill x1..x31 with their index, reset, wait for `ready`, then read all entries → all 0.
- Random write/read sequence checked against a scoreboard model including x0 and bypass rules: no mismatches over 10,000 cycles.
